// File: rtl/array_access_seq.sv
// array_access_seq: timed decoder-enable sequencer for peri_main.
// Single-cell or whole-array access with setup/pulse/hold phases.
module array_access_seq #(
  parameter int COL_NO      = 128,
  parameter int PAIR_ROW_NO = 64,
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 4,
  parameter int HOLD_CYC    = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_scan,
  input  logic [$clog2(COL_NO)-1:0]      req_col,
  input  logic [$clog2(PAIR_ROW_NO)-1:0] req_row,
  input  logic                           abort,
  output logic                           en,
  output logic [$clog2(COL_NO)-1:0]      col_sel,
  output logic [$clog2(PAIR_ROW_NO)-1:0] row_sel,
  output logic                           busy,
  output logic                           done,
  output logic                           aborted
);

  localparam int CW    = $clog2(COL_NO);
  localparam int RW    = $clog2(PAIR_ROW_NO);
  localparam int MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAXC  = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
  localparam int CNT_W = $clog2(MAXC) + 1;

  localparam logic [CNT_W-1:0] S_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] P_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] H_LD = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             scan_q, scan_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             last_cell;

  assign last_cell = (&col_q) & (&row_q);

  // Next-state, counter, address and next-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    scan_d    = scan_q;
    col_d     = col_q;
    row_d     = row_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    if (state_q != IDLE && abort) begin
      state_d   = IDLE;
      cnt_d     = '0;
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            scan_d  = req_scan;
            col_d   = req_scan ? '0 : req_col;
            row_d   = req_scan ? '0 : req_row;
            state_d = SETUP;
            cnt_d   = S_LD;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            state_d = PULSE;
            cnt_d   = P_LD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            state_d = HOLD;
            cnt_d   = H_LD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (scan_q && !last_cell) begin
            state_d = SETUP;
            cnt_d   = S_LD;
            col_d   = col_q + 1'b1;
            if (&col_q) begin
              row_d = row_q + 1'b1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end
      endcase
    end
    en_d    = (state_d == PULSE);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      scan_q    <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      scan_q    <= scan_d;
      col_q     <= col_d;
      row_q     <= row_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign req_ready = ready_q;
  assign en        = en_q;
  assign col_sel   = col_q;
  assign row_sel   = row_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_array_access_seq.sv
// tb_array_access_seq: scoreboard bench for array_access_seq.
// Default-parameter and small scan instances checked by event queue.
module tb_array_access_seq;

  localparam int K_ST  = 0;
  localparam int K_END = 1;
  localparam int K_DN  = 2;
  localparam int K_AB  = 3;

  typedef struct {
    int id;
    int kind;
    int col;
    int row;
    int cyc;
  } ev_t;

  ev_t q[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;

  logic rst_n;

  logic       rv0, scan0, abort0;
  logic [6:0] col_in0;
  logic [5:0] row_in0;
  logic       rdy0, en0, busy0, done0, ab0;
  logic [6:0] cs0;
  logic [5:0] rs0;

  logic       rv1, scan1, abort1;
  logic [1:0] col_in1;
  logic [0:0] row_in1;
  logic       rdy1, en1, busy1, done1, ab1;
  logic [1:0] cs1;
  logic [0:0] rs1;

  array_access_seq dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv0), .req_ready(rdy0),
    .req_scan(scan0), .req_col(col_in0), .req_row(row_in0),
    .abort(abort0), .en(en0),
    .col_sel(cs0), .row_sel(rs0),
    .busy(busy0), .done(done0), .aborted(ab0)
  );

  array_access_seq #(
    .COL_NO(4), .PAIR_ROW_NO(2),
    .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv1), .req_ready(rdy1),
    .req_scan(scan1), .req_col(col_in1), .req_row(row_in1),
    .abort(abort1), .en(en1),
    .col_sel(cs1), .row_sel(rs1),
    .busy(busy1), .done(done1), .aborted(ab1)
  );

  function automatic void chk(string n, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d",
               n, cyc, act, want);
    end
  endfunction

  function automatic void push_ev(int id, int k, int c, int r, int t);
    ev_t e;
    e.id = id; e.kind = k; e.col = c; e.row = r; e.cyc = t;
    q.push_back(e);
  endfunction

  function automatic void got(int id, int k, int c, int r);
    ev_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got dut%0d kind%0d (%0d,%0d) @%0d, expected none",
               id, k, c, r, cyc);
      return;
    end
    e = q.pop_front();
    if (e.id != id || e.kind != k || e.col != c ||
        e.row != r || e.cyc != cyc) begin
      bad++;
      $display("FAIL event: got dut%0d kind%0d (%0d,%0d) @%0d expected dut%0d kind%0d (%0d,%0d) @%0d",
               id, k, c, r, cyc, e.id, e.kind, e.col, e.row, e.cyc);
    end
  endfunction

  task automatic watch(input int id, input logic en, input logic enp,
                       input logic dn, input logic ab,
                       input int c, input int r, input int pc, input int pr);
    if (en && enp) begin
      total++;
      if (c != pc || r != pr) begin
        bad++;
        $display("FAIL sel_stable dut%0d @%0d: got (%0d,%0d) expected (%0d,%0d)",
                 id, cyc, c, r, pc, pr);
      end
    end
    if (en && !enp) got(id, K_ST, c, r);
    if (!en && enp) got(id, K_END, c, r);
    if (dn) got(id, K_DN, c, r);
    if (ab) got(id, K_AB, c, r);
  endtask

  logic en0_p = 1'b0, en1_p = 1'b0;
  int   pc0 = 0, pr0 = 0, pc1 = 0, pr1 = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      watch(0, en0, en0_p, done0, ab0, int'(cs0), int'(rs0), pc0, pr0);
      watch(1, en1, en1_p, done1, ab1, int'(cs1), int'(rs1), pc1, pr1);
    end
    en0_p = en0; pc0 = int'(cs0); pr0 = int'(rs0);
    en1_p = en1; pc1 = int'(cs1); pr1 = int'(rs1);
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_single0(input int c, input int r, input int e0);
    push_ev(0, K_ST, c, r, e0 + 2);
    push_ev(0, K_END, c, r, e0 + 6);
    push_ev(0, K_DN, c, r, e0 + 7);
  endtask

  int e0;

  initial begin
    rst_n = 1'b0;
    rv0 = 0; scan0 = 0; abort0 = 0; col_in0 = '0; row_in0 = '0;
    rv1 = 0; scan1 = 0; abort1 = 0; col_in1 = '0; row_in1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_en0", en0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_ready0", rdy0, 1);
    chk("rst_done0", done0, 0);
    chk("rst_ab0", ab0, 0);
    chk("rst_col0", cs0, 0);
    chk("rst_row0", rs0, 0);
    chk("rst_en1", en1, 0);
    chk("rst_ready1", rdy1, 1);
    rst_n = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);

    // single access 5/3
    rv0 = 1; scan0 = 0; col_in0 = 7'd5; row_in0 = 6'd3;
    e0 = cyc + 1;
    push_single0(5, 3, e0);
    @(negedge clk);
    rv0 = 0;
    for (int k = 0; k < 8; k++) begin
      chk("single_busy", busy0, (k < 7) ? 1 : 0);
      chk("single_ready", rdy0, (k >= 7) ? 1 : 0);
      chk("single_col", cs0, 5);
      chk("single_row", rs0, 3);
      @(negedge clk);
    end

    // abort in second pulse cycle
    rv0 = 1; col_in0 = 7'd2; row_in0 = 6'd7;
    e0 = cyc + 1;
    push_ev(0, K_ST, 2, 7, e0 + 2);
    push_ev(0, K_END, 2, 7, e0 + 4);
    push_ev(0, K_AB, 2, 7, e0 + 4);
    @(negedge clk);
    rv0 = 0;
    wait_until(e0 + 3);
    abort0 = 1;
    @(negedge clk);
    abort0 = 0;
    chk("abort_ready", rdy0, 1);
    chk("abort_busy", busy0, 0);
    chk("abort_en", en0, 0);
    wait_until(e0 + 10);

    // abort in final hold beats done
    rv0 = 1; col_in0 = 7'd127; row_in0 = 6'd63;
    e0 = cyc + 1;
    push_ev(0, K_ST, 127, 63, e0 + 2);
    push_ev(0, K_END, 127, 63, e0 + 6);
    push_ev(0, K_AB, 127, 63, e0 + 7);
    @(negedge clk);
    rv0 = 0;
    wait_until(e0 + 6);
    abort0 = 1;
    @(negedge clk);
    abort0 = 0;
    chk("hold_abort_done", done0, 0);
    chk("hold_abort_ab", ab0, 1);
    wait_until(e0 + 10);

    // abort while idle with simultaneous request
    rv0 = 1; abort0 = 1; col_in0 = 7'd0; row_in0 = 6'd0;
    e0 = cyc + 1;
    push_single0(0, 0, e0);
    @(negedge clk);
    rv0 = 0; abort0 = 0;
    chk("idle_abort_busy", busy0, 1);
    chk("idle_abort_ab", ab0, 0);
    wait_until(e0 + 9);

    // req_valid held: second acceptance in done cycle
    rv0 = 1; col_in0 = 7'd9; row_in0 = 6'd1;
    e0 = cyc + 1;
    push_single0(9, 1, e0);
    push_single0(9, 1, e0 + 8);
    wait_until(e0 + 7);
    chk("held_ready_done", rdy0, 1);
    chk("held_busy_done", busy0, 0);
    wait_until(e0 + 8);
    rv0 = 0;
    chk("held_ready_2nd", rdy0, 0);
    chk("held_busy_2nd", busy0, 1);
    wait_until(e0 + 17);

    // full scan on 4x2, 1/1/1
    rv1 = 1; scan1 = 1; col_in1 = 2'd3; row_in1 = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      push_ev(1, K_ST, i % 4, i / 4, e0 + 3 * i + 1);
      push_ev(1, K_END, i % 4, i / 4, e0 + 3 * i + 2);
    end
    push_ev(1, K_DN, 3, 1, e0 + 24);
    @(negedge clk);
    rv1 = 0;
    wait_until(e0 + 23);
    chk("scan_busy_last", busy1, 1);
    wait_until(e0 + 24);
    chk("scan_busy_done", busy1, 0);
    wait_until(e0 + 26);

    // reset mid-scan at cell (2,0)
    rv1 = 1; scan1 = 1;
    e0 = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      push_ev(1, K_ST, i, 0, e0 + 3 * i + 1);
      push_ev(1, K_END, i, 0, e0 + 3 * i + 2);
    end
    push_ev(1, K_ST, 2, 0, e0 + 7);
    push_ev(1, K_END, 0, 0, e0 + 8);
    @(negedge clk);
    rv1 = 0;
    wait_until(e0 + 7);
    chk("pre_rst_col1", cs1, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_en1", en1, 0);
    chk("mid_rst_busy1", busy1, 0);
    chk("mid_rst_ready1", rdy1, 1);
    chk("mid_rst_col1", cs1, 0);
    chk("mid_rst_row1", rs1, 0);
    chk("mid_rst_done1", done1, 0);
    chk("mid_rst_ab1", ab1, 0);
    chk("mid_rst_col0", cs0, 0);
    @(negedge clk);

    // fresh single on the small instance
    rv1 = 1; scan1 = 0; col_in1 = 2'd1; row_in1 = 1'b1;
    e0 = cyc + 1;
    push_ev(1, K_ST, 1, 1, e0 + 1);
    push_ev(1, K_END, 1, 1, e0 + 2);
    push_ev(1, K_DN, 1, 1, e0 + 3);
    @(negedge clk);
    rv1 = 0;
    wait_until(e0 + 5);

    // fresh default single after reset
    rv0 = 1; col_in0 = 7'd5; row_in0 = 6'd3;
    e0 = cyc + 1;
    push_single0(5, 3, e0);
    @(negedge clk);
    rv0 = 0;
    wait_until(e0 + 10);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_events: got %0d left in queue, expected 0",
               q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/array_access_seq.md
ARRAY_ACCESS_SEQ -- requirements
Module: array_access_seq

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  COL_NO, 128, column count, power of two, at least 2.
  PAIR_ROW_NO, 64, pair-row count, power of two, at least 2.
  SETUP_CYC, 2, address-setup cycles before en, at least 1.
  PULSE_CYC, 4, en-high cycles, at least 1.
  HOLD_CYC, 1, address-hold cycles after en, at least 1.
REQ-002 SHALL have ports (name, direction, width, meaning):
  clk  in  1  sole clock; all logic on rising edge.
  rst_n  in  1  reset, synchronous, active-low.
  req_valid  in  1  access request.
  req_ready  out  1  request accepted when req_valid&&req_ready at an edge.
  req_scan  in  1  1 = scan whole array from (col 0, row 0); 0 = single cell.
  req_col  in  $clog2(COL_NO)  single-cell column.
  req_row  in  $clog2(PAIR_ROW_NO)  single-cell pair-row.
  abort  in  1  terminate current access.
  en  out  1  decoder enable to peri_main.
  col_sel  out  $clog2(COL_NO)  column select to peri_main.
  row_sel  out  $clog2(PAIR_ROW_NO)  pair-row select to peri_main.
  busy  out  1  high in any state except IDLE.
  done  out  1  one-cycle pulse at normal completion.
  aborted  out  1  one-cycle pulse at abort completion.
REQ-003 SHALL register every output.

Function
REQ-004 SHALL implement FSM states IDLE, SETUP, PULSE, HOLD; one down-counter times each timed state.
REQ-005 IDLE: req_ready=1, en=0; on acceptance latch mode and address (req_col/req_row, or 0/0 if req_scan), go SETUP.
REQ-006 req_ready SHALL be 0 in all non-IDLE states; req_valid there is ignored.
REQ-007 SETUP SHALL last SETUP_CYC cycles with en=0 and col_sel/row_sel at the current cell.
REQ-008 PULSE SHALL last PULSE_CYC cycles with en=1; col_sel/row_sel SHALL NOT change while en=1.
REQ-009 HOLD SHALL last HOLD_CYC cycles with en=0 and selects unchanged.
REQ-010 Latency: with acceptance at edge E0, en SHALL be high exactly in cycles starting at edges E0+SETUP_CYC .. E0+SETUP_CYC+PULSE_CYC-1.
REQ-011 Single mode: after HOLD, done=1 for one cycle starting at edge E0+SETUP_CYC+PULSE_CYC+HOLD_CYC; FSM returns to IDLE in that same cycle.
REQ-012 Scan mode: after HOLD, if not last cell, advance address and enter SETUP with no gap cycle; column increments first; column COL_NO-1 wraps to 0 and increments row.
REQ-013 Last scan cell is (COL_NO-1, PAIR_ROW_NO-1); done SHALL pulse only after its HOLD; no wrap to (0,0).
REQ-014 Scan duration SHALL be COL_NO*PAIR_ROW_NO*(SETUP_CYC+PULSE_CYC+HOLD_CYC) cycles from E0 to done.
REQ-015 abort high at an edge in SETUP/PULSE/HOLD: FSM to IDLE, en=0 and aborted=1 for one cycle starting that edge; done SHALL NOT pulse.
REQ-016 abort in the final HOLD cycle SHALL take priority over done.
REQ-017 abort in IDLE SHALL be ignored; a simultaneous request SHALL be accepted normally.
REQ-018 A new request MAY be accepted in the cycle done or aborted is high (FSM already IDLE).
REQ-019 col_sel/row_sel SHALL hold their last value in IDLE.

Reset
REQ-020 rst_n=0 at an edge SHALL force IDLE, en=0, done=0, aborted=0, busy=0, req_ready=1, col_sel=0, row_sel=0, counters cleared.
REQ-021 Reset mid-access SHALL drop en at that edge and produce neither done nor aborted.

Verification
REQ-022 Single: req_col=5, req_row=3, defaults -> en high 4 cycles starting E0+2, selects 5/3 throughout, done at E0+7, busy high E0..E0+6.
REQ-023 Scan, COL_NO=4, PAIR_ROW_NO=2, S/P/H=1/1/1 -> 8 en pulses, order (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1), pulses 3 cycles apart, done at E0+24.
REQ-024 Abort during 2nd PULSE cycle of single access -> en low next cycle, aborted one cycle, no done, req_ready=1.
REQ-025 abort and done coincide (abort in final HOLD) -> aborted=1, done=0.
REQ-026 req_valid held high during busy -> exactly one acceptance; second accepted in done cycle, en restarts SETUP_CYC later.
REQ-027 rst_n=0 in mid-scan at cell (2,0) -> all outputs reset values next cycle, no done/aborted, fresh request behaves as REQ-022.
